// File: rtl/time_manager_nch.sv
// Multi-channel time manager: picks the earliest enabled time request and advances
// a monotonic current time to it, rejecting (and flagging) requests that would go backwards.
module time_manager_nch #(
    parameter int N          = 4,
    parameter int TIME_WIDTH = 32,
    parameter int IDX_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0][TIME_WIDTH-1:0]   time_in,
    input  logic [N-1:0]                   ch_en,
    input  logic                           hold,
    input  logic                           clr_err,
    output logic [TIME_WIDTH-1:0]          time_next,
    output logic [TIME_WIDTH-1:0]          time_curr,
    output logic [IDX_WIDTH-1:0]           win_idx,
    output logic [N-1:0]                   win_onehot,
    output logic                           advanced,
    output logic [15:0]                    step_count,
    output logic                           err_backstep
);

    if (N < 1 || N > 16) begin : g_bad_n
        $error("time_manager_nch: N must be in 1..16");
    end

    logic [TIME_WIDTH-1:0] time_curr_q, time_curr_d;
    logic [IDX_WIDTH-1:0]  win_idx_q, win_idx_d;
    logic [N-1:0]          win_onehot_q, win_onehot_d;
    logic                  advanced_q, advanced_d;
    logic [15:0]           step_count_q, step_count_d;
    logic                  err_backstep_q, err_backstep_d;

    logic [TIME_WIDTH-1:0] min_val;
    logic [IDX_WIDTH-1:0]  min_idx;
    logic                  any_en;
    logic                  backstep;
    logic                  win_valid;

    // Strict less-than keeps the first (lowest-index) channel on ties.
    always_comb begin
        any_en  = 1'b0;
        min_val = '0;
        min_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ch_en[i] && (!any_en || time_in[i] < min_val)) begin
                any_en  = 1'b1;
                min_val = time_in[i];
                min_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        backstep  = any_en && (min_val < time_curr_q);
        win_valid = any_en && !backstep;
        time_next = win_valid ? min_val : time_curr_q;
    end

    always_comb begin
        time_curr_d    = time_curr_q;
        win_idx_d      = win_idx_q;
        win_onehot_d   = win_onehot_q;
        advanced_d     = 1'b0;
        step_count_d   = step_count_q;
        err_backstep_d = err_backstep_q;

        if (!hold) begin
            time_curr_d  = time_next;
            advanced_d   = (time_next != time_curr_q);
            step_count_d = step_count_q + 16'(advanced_d);
            if (win_valid) begin
                win_idx_d    = min_idx;
                win_onehot_d = N'(1) << min_idx;
            end else begin
                win_onehot_d = '0;
            end
        end

        // A fresh backstep overrides a clear on the same edge; clear works during hold.
        if (!hold && backstep) begin
            err_backstep_d = 1'b1;
        end else if (clr_err) begin
            err_backstep_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_curr_q    <= '0;
            win_idx_q      <= '0;
            win_onehot_q   <= '0;
            advanced_q     <= 1'b0;
            step_count_q   <= '0;
            err_backstep_q <= 1'b0;
        end else begin
            time_curr_q    <= time_curr_d;
            win_idx_q      <= win_idx_d;
            win_onehot_q   <= win_onehot_d;
            advanced_q     <= advanced_d;
            step_count_q   <= step_count_d;
            err_backstep_q <= err_backstep_d;
        end
    end

    assign time_curr    = time_curr_q;
    assign win_idx      = win_idx_q;
    assign win_onehot   = win_onehot_q;
    assign advanced     = advanced_q;
    assign step_count   = step_count_q;
    assign err_backstep = err_backstep_q;

endmodule
